// File: rtl/dadz_vector_unit.sv
// dadz_vector_unit: activation-derivative engine for the backprop datapath.
// A latched vector of CHANNELS fixed-point activations is processed one
// channel per cycle through a single shared multiplier. The per-channel
// derivative (sigmoid, tanh, ReLU or linear) is saturated to DATA_W bits,
// and the full vector is returned over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for an input vector (in_ready high)
// BUSY   | computing channel idx, one channel per cycle
// DONE   | result vector held stable until out_ready

module dadz_vector_unit #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 10,
    parameter int CHANNELS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 mode,
    input  logic [CHANNELS*DATA_W-1:0] in_a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] out_dadz,
    output logic                       out_sat,
    output logic                       busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Operands carry two guard bits so ONE +/- a never overflows.
    localparam int EW    = DATA_W + 2;
    localparam int PW    = 2 * DATA_W + 4;

    localparam logic [1:0] M_SIG  = 2'd0;
    localparam logic [1:0] M_TANH = 2'd1;
    localparam logic [1:0] M_RELU = 2'd2;
    localparam logic [1:0] M_LIN  = 2'd3;

    localparam logic signed [EW-1:0] ONE_E = EW'(1) << FRAC_W;
    localparam logic [DATA_W-1:0]    ONE_D = DATA_W'(1) << FRAC_W;
    localparam logic signed [PW-1:0] MAXV  = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV  = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  a_lat [CHANNELS];
    logic [DATA_W-1:0]  res   [CHANNELS];
    logic [1:0]         mode_lat;
    logic [IDX_W-1:0]   idx;
    logic               sat_acc;

    logic [DATA_W-1:0]  a_cur;
    logic signed [EW-1:0] a_ext;
    logic signed [EW-1:0] op_a;
    logic signed [EW-1:0] op_b;
    logic signed [PW-1:0] op_a_w;
    logic signed [PW-1:0] op_b_w;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shr;
    logic [DATA_W-1:0]  ch_res;
    logic               ch_sat;

    assign out_sat = sat_acc;

    // Shared datapath: derivative and saturation flag for the current channel.
    always_comb begin
        a_cur  = a_lat[idx];
        a_ext  = {{2{a_cur[DATA_W-1]}}, a_cur};
        op_a   = ONE_E - a_ext;
        op_b   = (mode_lat == M_SIG) ? a_ext : (ONE_E + a_ext);
        op_a_w = {{(PW-EW){op_a[EW-1]}}, op_a};
        op_b_w = {{(PW-EW){op_b[EW-1]}}, op_b};
        prod   = op_a_w * op_b_w;
        shr    = prod >>> FRAC_W;
        ch_res = shr[DATA_W-1:0];
        ch_sat = 1'b0;
        if (shr > MAXV) begin
            ch_res = MAXV[DATA_W-1:0];
            ch_sat = 1'b1;
        end else if (shr < MINV) begin
            ch_res = MINV[DATA_W-1:0];
            ch_sat = 1'b1;
        end
        if (mode_lat == M_RELU) begin
            ch_res = (!a_ext[EW-1] && (a_ext != '0)) ? ONE_D : '0;
            ch_sat = 1'b0;
        end else if (mode_lat == M_LIN) begin
            ch_res = ONE_D;
            ch_sat = 1'b0;
        end
    end

    // Control FSM with registered handshake outputs and result slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            sat_acc   <= 1'b0;
            mode_lat  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                res[i]   <= '0;
                a_lat[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            a_lat[i] <= in_a[i*DATA_W +: DATA_W];
                        end
                        mode_lat <= mode;
                        idx      <= '0;
                        sat_acc  <= 1'b0;
                        state    <= S_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    res[idx] <= ch_res;
                    sat_acc  <= sat_acc | ch_sat;
                    if (idx == IDX_W'(CHANNELS - 1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Pack result slots onto the output bus, channel 0 in the low bits.
    always_comb begin
        out_dadz = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out_dadz[i*DATA_W +: DATA_W] = res[i];
        end
    end

endmodule
